// File: rtl/keypad_matrix_responder_pkg.sv
// Shared keypad definitions: key-code width, matrix geometry, scan polarity
// and the key-code to (row, column) mapping.
package keypad_matrix_responder_pkg;

  localparam int unsigned KEY_W       = 4;
  localparam int unsigned MATRIX_ROWS = 3;
  localparam int unsigned MATRIX_COLS = 3;
  localparam int unsigned CNT_W       = 28;

  localparam logic [KEY_W-1:0] KEY_IDLE = 4'd15;
  localparam logic [KEY_W-1:0] KEY_MAX  = 4'd8;

  // Column drive and row sense are both active-low.
  localparam logic COL_ACTIVE   = 1'b0;
  localparam logic ROW_ACTIVE   = 1'b0;
  localparam logic ROW_INACTIVE = 1'b1;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } key_pos_t;

  function automatic key_pos_t key_to_pos(input logic [KEY_W-1:0] key);
    key_pos_t pos;
    pos.r = 2'(key / 4'd3);
    pos.c = 2'(key % 4'd3);
    return pos;
  endfunction

endpackage

// File: rtl/keypad_matrix_responder_bounce_shaper.sv
// Contact-bounce generator: while run_i is high, emits BOUNCE_COUNT alternating
// half-periods of BOUNCE_STEP cycles starting at first_level_i, with done_o on the last cycle.
module bounce_shaper
  import keypad_matrix_responder_pkg::*;
#(
  parameter int unsigned BOUNCE_STEP  = 5_000,
  parameter int unsigned BOUNCE_COUNT = 6
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic first_level_i,
  output logic level_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(BOUNCE_STEP - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BOUNCE_COUNT - 1);

  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             step_last;
  logic             half_last;

  assign step_last = (step_q == STEP_LAST);
  assign half_last = (half_q == HALF_LAST);

  always_comb begin
    step_d = step_q;
    half_d = half_q;
    if (!run_i) begin
      step_d = '0;
      half_d = '0;
    end else if (step_last) begin
      step_d = '0;
      half_d = half_last ? '0 : half_q + 1'b1;
    end else begin
      step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_q <= '0;
      half_q <= '0;
    end else begin
      step_q <= step_d;
      half_q <= half_d;
    end
  end

  assign level_o = first_level_i ^ half_q[0];
  assign done_o  = run_i && step_last && half_last;

endmodule

// File: rtl/keypad_matrix_responder.sv
// Emulated 3x3 keypad: answers the active-low column scan with registered
// row-sense levels for a commanded key press, including make/break bounce.
module keypad_matrix_responder
  import keypad_matrix_responder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 2_500_000,
  parameter int unsigned BOUNCE_STEP  = 5_000,
  parameter int unsigned BOUNCE_COUNT = 6,
  parameter int unsigned GAP_CYCLES   = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] column,
  input  logic       press_valid,
  input  logic [3:0] press_key,
  output logic       press_ready,
  output logic       busy,
  output logic [3:0] active_key,
  output logic [2:0] row
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MAKE  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_BREAK = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam bit               BOUNCE_EN = (BOUNCE_COUNT != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [2:0]       row_q, row_d;

  logic     shaper_run;
  logic     shaper_level;
  logic     shaper_done;
  logic     contact;
  key_pos_t pos;

  assign shaper_run = (state_q == ST_MAKE) || (state_q == ST_BREAK);

  bounce_shaper #(
    .BOUNCE_STEP  (BOUNCE_STEP),
    .BOUNCE_COUNT (BOUNCE_COUNT)
  ) u_bounce_shaper (
    .clk_i         (clk),
    .reset_i       (reset),
    .run_i         (shaper_run),
    .first_level_i (state_q == ST_MAKE),
    .level_o       (shaper_level),
    .done_o        (shaper_done)
  );

  always_comb begin
    case (state_q)
      ST_MAKE, ST_BREAK: contact = shaper_level;
      ST_HOLD:           contact = 1'b1;
      default:           contact = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    case (state_q)
      ST_IDLE: begin
        if (press_valid && (press_key <= KEY_MAX)) begin
          key_d   = press_key;
          cnt_d   = '0;
          state_d = BOUNCE_EN ? ST_MAKE : ST_HOLD;
        end
      end
      ST_MAKE: begin
        if (shaper_done) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = BOUNCE_EN ? ST_BREAK : ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (shaper_done) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          key_d   = KEY_IDLE;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        key_d   = KEY_IDLE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only the latched key's column is sensed; other columns never affect row.
  always_comb begin
    pos   = key_to_pos(key_q);
    row_d = {3{ROW_INACTIVE}};
    if (contact && (column[pos.c] == COL_ACTIVE)) begin
      row_d[pos.r] = ROW_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= KEY_IDLE;
      row_q   <= {3{ROW_INACTIVE}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      row_q   <= row_d;
    end
  end

  assign press_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign active_key  = key_q;
  assign row         = row_q;

endmodule
